// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard_if
//  Description : Read, writeback and claim signal bundle for the register
//                file scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_scoreboard_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
);
  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic [DATA_W-1:0]   rd_data_a;
  logic [DATA_W-1:0]   rd_data_b;
  logic                rd_busy_a;
  logic                rd_busy_b;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                claim_en;
  logic [ADDR_W-1:0]   claim_addr;
  logic [NUM_REGS-1:0] busy_vec;
  logic                claim_err;

  // Pipeline side: issues reads, writebacks and claims
  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, busy_vec, claim_err
  );

  // Register file side
  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, busy_vec, claim_err
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Two-read / one-write register file with write-through bypass
//                and a per-register pending-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int R0_ZERO  = 0
) (
  input  logic               clk,
  input  logic               reset,
  regfile_scoreboard_if.slave bus
);

  localparam int c_NUM_PORTS = 2;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_claimErr;

  logic                w_wrEff;
  logic                w_claimEff;
  logic                w_claimConflict;
  logic [NUM_REGS-1:0] w_busyNext;

  logic [ADDR_W-1:0]   w_rdAddr [c_NUM_PORTS];
  logic [DATA_W-1:0]   w_rdData [c_NUM_PORTS];
  logic                w_rdBusy [c_NUM_PORTS];

  // With R0_ZERO set, address 0 absorbs writes and claims silently
  assign w_wrEff    = bus.wr_en    && !((R0_ZERO != 0) && (bus.wr_addr    == '0));
  assign w_claimEff = bus.claim_en && !((R0_ZERO != 0) && (bus.claim_addr == '0));

  // A claim on a busy register is only an error if no writeback retires it now
  assign w_claimConflict = w_claimEff && r_busy[bus.claim_addr] &&
                           !(w_wrEff && (bus.wr_addr == bus.claim_addr));

  assign w_rdAddr[0] = bus.rd_addr_a;
  assign w_rdAddr[1] = bus.rd_addr_b;

  generate
    for (genvar p = 0; p < c_NUM_PORTS; p++) begin : g_rdPort
      logic w_isZero;
      logic w_wrHit;
      logic w_claimHit;

      assign w_isZero   = (R0_ZERO != 0) && (w_rdAddr[p] == '0);
      assign w_wrHit    = w_wrEff    && (bus.wr_addr    == w_rdAddr[p]);
      assign w_claimHit = w_claimEff && (bus.claim_addr == w_rdAddr[p]);

      // Same-cycle writeback data is forwarded and counts as ready unless a
      // new producer claims the register in the same cycle
      assign w_rdData[p] = w_isZero ? '0 :
                           w_wrHit  ? bus.wr_data : r_regs[w_rdAddr[p]];
      assign w_rdBusy[p] = !w_isZero && r_busy[w_rdAddr[p]] &&
                           !(w_wrHit && !w_claimHit);
    end
  endgenerate

  assign bus.rd_data_a = w_rdData[0];
  assign bus.rd_data_b = w_rdData[1];
  assign bus.rd_busy_a = w_rdBusy[0];
  assign bus.rd_busy_b = w_rdBusy[1];
  assign bus.busy_vec  = r_busy;
  assign bus.claim_err = r_claimErr;

  // Next scoreboard: writeback clears first, claim sets last so the new producer wins
  always_comb begin
    w_busyNext = r_busy;
    if (w_wrEff) begin
      w_busyNext[bus.wr_addr] = 1'b0;
    end
    if (w_claimEff) begin
      w_busyNext[bus.claim_addr] = 1'b1;
    end
  end

  // Register file storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wrEff) begin
      r_regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Scoreboard bits and one-cycle claim error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy     <= '0;
      r_claimErr <= 1'b0;
    end else begin
      r_busy     <= w_busyNext;
      r_claimErr <= w_claimConflict;
    end
  end

endmodule
`default_nettype wire
